// File: rtl/bus_if_types_pkg.sv
// Shared bus transfer types, responder FSM states and lane helpers.
package bus_if_types_pkg;

   typedef enum logic {
      READ  = 1'b0,
      WRITE = 1'b1
   } ttype_e;

   typedef enum logic [1:0] {
      BYTE = 2'd0,
      HALF = 2'd1,
      WORD = 2'd2
   } tsize_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } resp_state_e;

   typedef struct packed {
      ttype_e      ttype;
      tsize_e      tsize;
      logic [31:0] addr;
      logic [31:0] wdata;
   } bus_req_t;

   // Byte-lane enables for a store of the given size at the given byte offset.
   function automatic logic [3:0] lane_enables(tsize_e sz, logic [1:0] ofs);
      logic [3:0] be;
      be = 4'b0000;
      case (sz)
         BYTE:    be = 4'b0001 << ofs;
         HALF:    be = ofs[1] ? 4'b1100 : 4'b0011;
         WORD:    be = 4'b1111;
         default: be = 4'b0000;
      endcase
      return be;
   endfunction

endpackage

// File: rtl/sram_byte_array.sv
// Byte-writable word storage: synchronous lane-masked write, asynchronous read.
module sram_byte_array #(
   parameter int unsigned DEPTH_WORDS = 1024,
   localparam int unsigned IDX_W = $clog2(DEPTH_WORDS)
) (
   input  logic             clk_i,
   input  logic             we_i,
   input  logic [IDX_W-1:0] idx_i,
   input  logic [3:0]       be_i,
   input  logic [31:0]      wdata_i,
   output logic [31:0]      rdata_o
);

   logic [3:0][7:0] mem_q [DEPTH_WORDS];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int b = 0; b < 4; b++) begin
            if (be_i[b]) mem_q[idx_i][b] <= wdata_i[8*b +: 8];
         end
      end
   end

   assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/bus_sram_responder.sv
// Bus slave fronting a byte-addressable SRAM with a fixed number of wait states
// per transfer and alignment/range error reporting.
module bus_sram_responder
   import bus_if_types_pkg::*;
#(
   parameter logic [31:0]  BASE_ADDR   = 32'h0000_0000,
   parameter int unsigned  DEPTH_WORDS = 1024,
   parameter int unsigned  WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        bstart,
   input  logic        breq,
   input  ttype_e      ttype,
   input  tsize_e      tsize,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic [31:0] rdata,
   output logic        bdone,
   output logic        berr
);

   localparam int unsigned IDX_W     = $clog2(DEPTH_WORDS);
   localparam logic [32:0] SPAN      = 33'(DEPTH_WORDS) << 2;
   localparam bit          ZERO_WAIT = (WAIT_STATES == 0);

   resp_state_e state_q;
   logic [3:0]  cnt_q;
   bus_req_t    req_q;
   logic [31:0] rdata_q;
   logic        bdone_q;
   logic        berr_q;

   bus_req_t    cur_c;
   logic [32:0] diff_c;
   logic        err_c;
   logic        accept_c;
   logic        go_resp_c;
   logic        we_c;
   logic [3:0]  be_c;
   logic [31:0] wlanes_c;
   logic [31:0] word_c;
   logic [31:0] shifted_c;
   logic [31:0] load_c;

   // In IDLE the live bus is decoded so a zero-wait response sees the new request.
   always_comb begin
      cur_c = req_q;
      if (state_q == ST_IDLE) begin
         cur_c.ttype = ttype;
         cur_c.tsize = tsize;
         cur_c.addr  = addr;
         cur_c.wdata = wdata;
      end
   end

   assign accept_c  = (state_q == ST_IDLE) && bstart && breq;
   assign go_resp_c = (accept_c && ZERO_WAIT) ||
                      ((state_q == ST_WAIT) && (cnt_q == 4'd1));

   // Bit 32 of the difference is the borrow, i.e. addr below the window.
   assign diff_c = {1'b0, cur_c.addr} - {1'b0, BASE_ADDR};

   always_comb begin
      err_c = 1'b0;
      case (cur_c.tsize)
         BYTE:    err_c = 1'b0;
         HALF:    err_c = cur_c.addr[0];
         WORD:    err_c = (cur_c.addr[1:0] != 2'b00);
         default: err_c = 1'b1;
      endcase
      if (diff_c[32]) err_c = 1'b1;
      if ({1'b0, diff_c[31:0]} >= SPAN) err_c = 1'b1;
   end

   assign be_c = lane_enables(cur_c.tsize, cur_c.addr[1:0]);

   always_comb begin
      case (cur_c.tsize)
         BYTE:    wlanes_c = {4{cur_c.wdata[7:0]}};
         HALF:    wlanes_c = {2{cur_c.wdata[15:0]}};
         default: wlanes_c = cur_c.wdata;
      endcase
   end

   // Commit happens on the edge that leaves RESP; reset suppresses it.
   assign we_c = (state_q == ST_RESP) && (req_q.ttype == WRITE) && !err_c && !rst;

   sram_byte_array #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_mem (
      .clk_i   (clk),
      .we_i    (we_c),
      .idx_i   (diff_c[IDX_W+1:2]),
      .be_i    (be_c),
      .wdata_i (wlanes_c),
      .rdata_o (word_c)
   );

   assign shifted_c = word_c >> {cur_c.addr[1:0], 3'b000};

   always_comb begin
      case (cur_c.tsize)
         BYTE:    load_c = {24'h0, shifted_c[7:0]};
         HALF:    load_c = {16'h0, shifted_c[15:0]};
         default: load_c = shifted_c;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         req_q   <= '0;
         rdata_q <= 32'h0;
         bdone_q <= 1'b0;
         berr_q  <= 1'b0;
      end else begin
         bdone_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accept_c) begin
                  req_q   <= cur_c;
                  cnt_q   <= 4'(WAIT_STATES);
                  state_q <= ZERO_WAIT ? ST_RESP : ST_WAIT;
               end
            end
            ST_WAIT: begin
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) state_q <= ST_RESP;
            end
            ST_RESP: state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
         endcase
         if (go_resp_c) begin
            bdone_q <= 1'b1;
            berr_q  <= err_c;
            if (err_c) rdata_q <= 32'h0;
            else if (cur_c.ttype == READ) rdata_q <= load_c;
         end
      end
   end

   assign rdata = rdata_q;
   assign bdone = bdone_q;
   assign berr  = berr_q;

endmodule

// File: tb/tb_bus_sram_responder.sv
// Directed bench: one-wait-state responder driven from a vector table plus
// reset-abort sequences, and a zero-wait responder under back-to-back requests.
module tb_bus_sram_responder;
   import bus_if_types_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        bstart, breq;
   ttype_e      ttype;
   tsize_e      tsize;
   logic [31:0] addr, wdata, rdata;
   logic        bdone, berr;

   logic        bstart2, breq2;
   ttype_e      ttype2;
   tsize_e      tsize2;
   logic [31:0] addr2, wdata2, rdata2;
   logic        bdone2, berr2;

   bus_sram_responder #(
      .BASE_ADDR   (32'h0000_0000),
      .DEPTH_WORDS (16),
      .WAIT_STATES (1)
   ) dut (
      .clk (clk), .rst (rst), .bstart (bstart), .breq (breq),
      .ttype (ttype), .tsize (tsize), .addr (addr), .wdata (wdata),
      .rdata (rdata), .bdone (bdone), .berr (berr)
   );

   bus_sram_responder #(
      .BASE_ADDR   (32'h0000_0100),
      .DEPTH_WORDS (16),
      .WAIT_STATES (0)
   ) dut0 (
      .clk (clk), .rst (rst), .bstart (bstart2), .breq (breq2),
      .ttype (ttype2), .tsize (tsize2), .addr (addr2), .wdata (wdata2),
      .rdata (rdata2), .bdone (bdone2), .berr (berr2)
   );

   typedef struct {
      ttype_e      t;
      tsize_e      s;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   int checks   = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Starts at a negedge, returns at the negedge after the response cycle.
   task automatic xfer(input ttype_e t, input tsize_e s, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd,
                       output logic er, output int lat);
      lat = -1; rd = 32'h0; er = 1'b0;
      ttype = t; tsize = s; addr = a; wdata = d; bstart = 1'b1; breq = 1'b1;
      @(posedge clk);
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (n == 1) begin
            bstart = 1'b0; breq = 1'b0;
            addr = ~a; wdata = ~d; tsize = WORD;
            ttype = (t == READ) ? WRITE : READ;
         end
         if (bdone === 1'b1) begin
            rd = rdata; er = berr; lat = n;
            break;
         end
      end
      @(negedge clk);
   endtask

   vec_t vecs [20];
   vec_t st   [7];

   logic [31:0] rd;
   logic        er;
   int          lat;
   int          last, idx;

   initial begin
      vecs[0]  = '{WRITE, WORD, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0};
      vecs[1]  = '{READ,  WORD, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0};
      vecs[2]  = '{WRITE, BYTE, 32'h13, 32'hFFFFFF5A, 32'hDEADBEEF, 1'b0};
      vecs[3]  = '{READ,  WORD, 32'h10, 32'h0,        32'h5AADBEEF, 1'b0};
      vecs[4]  = '{READ,  BYTE, 32'h13, 32'h0,        32'h0000005A, 1'b0};
      vecs[5]  = '{READ,  HALF, 32'h11, 32'h0,        32'h0,        1'b1};
      vecs[6]  = '{WRITE, WORD, 32'h12, 32'h12345678, 32'h0,        1'b1};
      vecs[7]  = '{READ,  WORD, 32'h10, 32'h0,        32'h5AADBEEF, 1'b0};
      vecs[8]  = '{WRITE, WORD, 32'h3C, 32'hCAFEF00D, 32'h5AADBEEF, 1'b0};
      vecs[9]  = '{READ,  WORD, 32'h3C, 32'h0,        32'hCAFEF00D, 1'b0};
      vecs[10] = '{READ,  WORD, 32'h40, 32'h0,        32'h0,        1'b1};
      vecs[11] = '{WRITE, HALF, 32'h3E, 32'hAAAA1234, 32'h0,        1'b0};
      vecs[12] = '{READ,  HALF, 32'h3E, 32'h0,        32'h00001234, 1'b0};
      vecs[13] = '{READ,  HALF, 32'h3C, 32'h0,        32'h0000F00D, 1'b0};
      vecs[14] = '{READ,  BYTE, 32'h3D, 32'h0,        32'h000000F0, 1'b0};
      vecs[15] = '{READ,  WORD, 32'h3C, 32'h0,        32'h1234F00D, 1'b0};
      vecs[16] = '{READ,  tsize_e'(2'd3), 32'h10, 32'h0, 32'h0,     1'b1};
      vecs[17] = '{READ,  WORD, 32'h10, 32'h0,        32'h5AADBEEF, 1'b0};
      vecs[18] = '{READ,  HALF, 32'h12, 32'h0,        32'h00005AAD, 1'b0};
      vecs[19] = '{READ,  WORD, 32'h10, 32'h0,        32'h5AADBEEF, 1'b0};

      st[0] = '{WRITE, WORD, 32'h100, 32'hA1A2A3A4, 32'h0,        1'b0};
      st[1] = '{WRITE, WORD, 32'h104, 32'hB1B2B3B4, 32'h0,        1'b0};
      st[2] = '{READ,  WORD, 32'h100, 32'h0,        32'hA1A2A3A4, 1'b0};
      st[3] = '{READ,  BYTE, 32'h106, 32'h0,        32'h000000B2, 1'b0};
      st[4] = '{READ,  WORD, 32'h0FC, 32'h0,        32'h0,        1'b1};
      st[5] = '{READ,  WORD, 32'h140, 32'h0,        32'h0,        1'b1};
      st[6] = '{READ,  HALF, 32'h104, 32'h0,        32'h0000B3B4, 1'b0};

      rst = 1'b1;
      bstart = 1'b0; breq = 1'b0; ttype = READ; tsize = WORD; addr = '0; wdata = '0;
      bstart2 = 1'b0; breq2 = 1'b0; ttype2 = READ; tsize2 = WORD; addr2 = '0; wdata2 = '0;
      repeat (2) @(negedge clk);
      chk("reset_bdone", 32'(bdone), 32'h0);
      chk("reset_berr",  32'(berr),  32'h0);
      chk("reset_rdata", rdata,      32'h0);
      chk("reset_bdone0", 32'(bdone2), 32'h0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 20; i++) begin
         xfer(vecs[i].t, vecs[i].s, vecs[i].a, vecs[i].d, rd, er, lat);
         chk($sformatf("v%0d_latency", i), 32'(lat), 32'd2);
         chk($sformatf("v%0d_berr", i),    32'(er),  32'(vecs[i].exp_err));
         chk($sformatf("v%0d_rdata", i),   rd,       vecs[i].exp_rd);
         chk($sformatf("v%0d_pulse_end", i), 32'(bdone), 32'h0);
      end

      // Reset while a store sits in WAIT: store is dropped, outputs clear.
      ttype = WRITE; tsize = WORD; addr = 32'h10; wdata = 32'h11111111;
      bstart = 1'b1; breq = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bstart = 1'b0; breq = 1'b0;
      rst = 1'b1;
      #1;
      chk("rst_wait_rdata", rdata,      32'h0);
      chk("rst_wait_berr",  32'(berr),  32'h0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_wait_bdone", 32'(bdone), 32'h0);
      end
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("post_rst_bdone", 32'(bdone), 32'h0);
      end
      xfer(READ, WORD, 32'h10, 32'h0, rd, er, lat);
      chk("rst_wait_old_data", rd, 32'h5AADBEEF);

      // Reset inside the RESP cycle: pulse cut short, store not committed.
      ttype = WRITE; tsize = WORD; addr = 32'h10; wdata = 32'h22222222;
      bstart = 1'b1; breq = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bstart = 1'b0; breq = 1'b0;
      @(negedge clk);
      chk("resp_bdone_up", 32'(bdone), 32'h1);
      rst = 1'b1;
      #1;
      chk("rst_resp_bdone", 32'(bdone), 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      xfer(READ, WORD, 32'h10, 32'h0, rd, er, lat);
      chk("rst_resp_old_data", rd, 32'h5AADBEEF);

      // Zero-wait responder with request held: one response every second cycle.
      idx  = 0;
      last = -1;
      ttype2 = st[0].t; tsize2 = st[0].s; addr2 = st[0].a; wdata2 = st[0].d;
      bstart2 = 1'b1; breq2 = 1'b1;
      for (int n = 1; n <= 60 && idx < 7; n++) begin
         @(negedge clk);
         if (bdone2 === 1'b1) begin
            chk($sformatf("s%0d_gap", idx),   32'(n - last), 32'd2);
            chk($sformatf("s%0d_berr", idx),  32'(berr2),    32'(st[idx].exp_err));
            chk($sformatf("s%0d_rdata", idx), rdata2,        st[idx].exp_rd);
            last = n;
            idx++;
            if (idx < 7) begin
               ttype2 = st[idx].t; tsize2 = st[idx].s;
               addr2 = st[idx].a;  wdata2 = st[idx].d;
            end
         end
      end
      bstart2 = 1'b0; breq2 = 1'b0;
      chk("stream_count", 32'(idx), 32'd7);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
